// File: rtl/avl_mem_model.sv
// rtl/avl_mem_model.sv - word-addressed 32-bit RAM model with single, side, burst-read and burst-write ports
module avl_mem_model #(
  parameter int MEM_AW  = 12,
  parameter int BURST_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        address,
  input  logic [3:0]         byteenable,
  input  logic               write,
  input  logic [31:0]        writedata,
  input  logic               read,
  output logic [31:0]        readdata,
  output logic               readdatavalid,
  input  logic               wr_port_valid,
  input  logic [31:0]        wr_port_data,
  input  logic [31:0]        wr_port_addr,
  output logic               rx_waitrequest,
  input  logic [BURST_W-1:0] rx_burstcount,
  input  logic [31:0]        rx_address,
  input  logic               rx_read,
  output logic [31:0]        rx_readdata,
  output logic               rx_readdatavalid,
  output logic               tx_waitrequest,
  input  logic [BURST_W-1:0] tx_burstcount,
  input  logic [31:0]        tx_address,
  input  logic               tx_write,
  input  logic [31:0]        tx_writedata
);

  localparam int                 DEPTH  = 1 << MEM_AW;
  localparam logic [MEM_AW-1:0]  ONE_AW = 1;
  localparam logic [BURST_W-1:0] ONE_BC = 1;

  // Storage powers up zeroed and is deliberately untouched by rst_n.
  logic [31:0] mem [DEPTH] = '{default: '0};

  logic [MEM_AW-1:0]  main_idx, side_idx, rx_cmd_idx, tx_cmd_idx, tx_idx;
  logic [MEM_AW-1:0]  rx_ptr, tx_ptr;
  logic [BURST_W-1:0] rx_rem, tx_rem, rx_cnt_eff, tx_cnt_eff;
  logic [31:0]        main_merged;
  logic               tx_fire;
  logic               unused_addr_bits;

  assign main_idx   = address[MEM_AW+1:2];
  assign side_idx   = wr_port_addr[MEM_AW+1:2];
  assign rx_cmd_idx = rx_address[MEM_AW+1:2];
  assign tx_cmd_idx = tx_address[MEM_AW+1:2];

  assign unused_addr_bits = ^{address[31:MEM_AW+2], address[1:0],
                              wr_port_addr[31:MEM_AW+2], wr_port_addr[1:0],
                              rx_address[31:MEM_AW+2], rx_address[1:0],
                              tx_address[31:MEM_AW+2], tx_address[1:0]};

  assign rx_cnt_eff = (rx_burstcount == '0) ? ONE_BC : rx_burstcount;
  assign tx_cnt_eff = (tx_burstcount == '0) ? ONE_BC : tx_burstcount;

  assign rx_waitrequest = !rst_n || (rx_rem != '0);
  assign tx_waitrequest = !rst_n;

  // A beat with no burst in flight starts a new one from the presented address.
  assign tx_fire = tx_write && rst_n;
  assign tx_idx  = (tx_rem == '0) ? tx_cmd_idx : tx_ptr;

  always_comb begin
    main_merged = mem[main_idx];
    for (int i = 0; i < 4; i++) begin
      if (byteenable[i]) main_merged[8*i +: 8] = writedata[8*i +: 8];
    end
  end

  // Later assignments win on a shared word: tx over side port over main port.
  always_ff @(posedge clk) begin
    if (write)         mem[main_idx] <= main_merged;
    if (wr_port_valid) mem[side_idx] <= wr_port_data;
    if (tx_fire)       mem[tx_idx]   <= tx_writedata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ptr <= '0;
      tx_rem <= '0;
    end else if (tx_write) begin
      tx_ptr <= tx_idx + ONE_AW;
      tx_rem <= ((tx_rem == '0) ? tx_cnt_eff : tx_rem) - ONE_BC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= mem[main_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ptr           <= '0;
      rx_rem           <= '0;
      rx_readdata      <= '0;
      rx_readdatavalid <= 1'b0;
    end else if (rx_rem != '0) begin
      rx_readdata      <= mem[rx_ptr];
      rx_readdatavalid <= 1'b1;
      rx_ptr           <= rx_ptr + ONE_AW;
      rx_rem           <= rx_rem - ONE_BC;
    end else begin
      rx_readdatavalid <= 1'b0;
      if (rx_read) begin
        rx_ptr <= rx_cmd_idx;
        rx_rem <= rx_cnt_eff;
      end
    end
  end

endmodule

// File: tb/tb_avl_mem_model.sv
// tb/tb_avl_mem_model.sv - randomized self-checking bench for avl_mem_model against an array reference
module tb_avl_mem_model;
  localparam int MEM_AW  = 12;
  localparam int BURST_W = 12;
  localparam int DEPTH   = 1 << MEM_AW;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [31:0]        address, writedata, readdata, wr_port_data, wr_port_addr;
  logic [3:0]         byteenable;
  logic               write, read, readdatavalid, wr_port_valid;
  logic               rx_waitrequest, rx_read, rx_readdatavalid, tx_waitrequest, tx_write;
  logic [BURST_W-1:0] rx_burstcount, tx_burstcount;
  logic [31:0]        rx_address, rx_readdata, tx_address, tx_writedata;

  int total = 0;
  int bad   = 0;
  logic [31:0] ref_mem [DEPTH];

  avl_mem_model #(.MEM_AW(MEM_AW), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .address(address), .byteenable(byteenable), .write(write), .writedata(writedata),
    .read(read), .readdata(readdata), .readdatavalid(readdatavalid),
    .wr_port_valid(wr_port_valid), .wr_port_data(wr_port_data), .wr_port_addr(wr_port_addr),
    .rx_waitrequest(rx_waitrequest), .rx_burstcount(rx_burstcount), .rx_address(rx_address),
    .rx_read(rx_read), .rx_readdata(rx_readdata), .rx_readdatavalid(rx_readdatavalid),
    .tx_waitrequest(tx_waitrequest), .tx_burstcount(tx_burstcount), .tx_address(tx_address),
    .tx_write(tx_write), .tx_writedata(tx_writedata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1);
  end

  function automatic int widx(input logic [31:0] a);
    return int'(a[MEM_AW+1:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] alias_addr(input int w);
    return ($urandom << (MEM_AW + 2)) | (32'(w) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic idle();
    address = '0; byteenable = '0; write = 0; writedata = '0; read = 0;
    wr_port_valid = 0; wr_port_data = '0; wr_port_addr = '0;
    rx_burstcount = '0; rx_address = '0; rx_read = 0;
    tx_burstcount = '0; tx_address = '0; tx_write = 0; tx_writedata = '0;
  endtask

  task automatic main_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be; write = 1;
    @(negedge clk);
    write = 0;
    ref_mem[widx(a)] = merge(ref_mem[widx(a)], d, be);
  endtask

  task automatic side_write(input logic [31:0] a, input logic [31:0] d);
    wr_port_addr = a; wr_port_data = d; wr_port_valid = 1;
    @(negedge clk);
    wr_port_valid = 0;
    ref_mem[widx(a)] = d;
  endtask

  task automatic main_read(input logic [31:0] a);
    address = a; read = 1;
    @(negedge clk);
    read = 0;
  endtask

  task automatic tx_beat(input logic [31:0] a, input logic [BURST_W-1:0] cnt, input logic [31:0] d);
    tx_address = a; tx_burstcount = cnt; tx_writedata = d; tx_write = 1;
    @(negedge clk);
    tx_write = 0;
  endtask

  task automatic rx_start(input logic [31:0] a, input logic [BURST_W-1:0] cnt);
    rx_address = a; rx_burstcount = cnt; rx_read = 1;
    @(negedge clk);
    rx_read = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'h0); end
    total++; if (readdatavalid !== 1'b0) begin bad++; $display("FAIL reset_readdatavalid got=%b exp=0", readdatavalid); end
    total++; if (rx_readdata !== 32'h0) begin bad++; $display("FAIL reset_rx_readdata got=%h exp=%h", rx_readdata, 32'h0); end
    total++; if (rx_readdatavalid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_readdatavalid); end
    total++; if (rx_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_rx_wait got=%b exp=1", rx_waitrequest); end
    total++; if (tx_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_tx_wait got=%b exp=1", tx_waitrequest); end
    rst_n = 1;
    @(negedge clk);
    total++; if (rx_waitrequest !== 1'b0) begin bad++; $display("FAIL post_reset_rx_wait got=%b exp=0", rx_waitrequest); end
    total++; if (tx_waitrequest !== 1'b0) begin bad++; $display("FAIL post_reset_tx_wait got=%b exp=0", tx_waitrequest); end
  endtask

  task automatic test_main_port();
    main_read(32'h5000_0040);
    total++; if (readdatavalid !== 1'b1) begin bad++; $display("FAIL first_read_valid got=%b exp=1", readdatavalid); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL first_read_data got=%h exp=%h", readdata, 32'h0); end
    @(negedge clk);
    total++; if (readdatavalid !== 1'b0) begin bad++; $display("FAIL read_valid_pulse got=%b exp=0", readdatavalid); end
    main_write(32'h5000_008C, 32'h0000_ABCD, 4'h3);
    main_read(32'h5000_008C);
    total++; if (readdata !== 32'h0000_ABCD) begin bad++; $display("FAIL be_write1 got=%h exp=%h", readdata, 32'h0000_ABCD); end
    main_write(32'h5000_008C, 32'hFFFF_1234, 4'h3);
    main_read(32'h5000_008C);
    total++; if (readdata !== 32'h0000_1234) begin bad++; $display("FAIL be_write2 got=%h exp=%h", readdata, 32'h0000_1234); end
    @(negedge clk);
    total++; if (readdata !== 32'h0000_1234) begin bad++; $display("FAIL readdata_hold got=%h exp=%h", readdata, 32'h0000_1234); end
  endtask

  task automatic test_side_alias();
    side_write(32'h0000_0100, 32'hDEAD_BEEF);
    main_read(32'h0000_4100);
    total++; if (readdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL side_alias got=%h exp=%h", readdata, 32'hDEAD_BEEF); end
  endtask

  task automatic test_collision();
    address = 32'h300; writedata = 32'h11; byteenable = 4'hF; write = 1;
    wr_port_addr = 32'h300; wr_port_data = 32'h22; wr_port_valid = 1;
    @(negedge clk);
    write = 0; wr_port_valid = 0;
    ref_mem[widx(32'h300)] = 32'h22;
    main_read(32'h300);
    total++; if (readdata !== 32'h22) begin bad++; $display("FAIL side_over_main got=%h exp=%h", readdata, 32'h22); end
    address = 32'h300; writedata = 32'h55; byteenable = 4'hF; write = 1; read = 1;
    @(negedge clk);
    write = 0; read = 0;
    ref_mem[widx(32'h300)] = 32'h55;
    total++; if (readdata !== 32'h22) begin bad++; $display("FAIL read_first got=%h exp=%h", readdata, 32'h22); end
    main_read(32'h300);
    total++; if (readdata !== 32'h55) begin bad++; $display("FAIL write_after_rf got=%h exp=%h", readdata, 32'h55); end
    address = 32'h310; writedata = 32'hC0C0_C0C0; byteenable = 4'hF; write = 1;
    wr_port_addr = 32'h310; wr_port_data = 32'hB0B0_B0B0; wr_port_valid = 1;
    tx_beat(32'h310, 1, 32'hA0A0_A0A0);
    write = 0; wr_port_valid = 0;
    ref_mem[widx(32'h310)] = 32'hA0A0_A0A0;
    main_read(32'h310);
    total++; if (readdata !== 32'hA0A0_A0A0) begin bad++; $display("FAIL tx_priority got=%h exp=%h", readdata, 32'hA0A0_A0A0); end
  endtask

  task automatic test_burst();
    tx_beat(32'h200, 4, 32'd1);
    tx_beat($urandom, BURST_W'($urandom), 32'd2);
    @(negedge clk);
    tx_beat($urandom, BURST_W'($urandom), 32'd3);
    tx_beat($urandom, BURST_W'($urandom), 32'd4);
    for (int i = 0; i < 4; i++) ref_mem[widx(32'h200) + i] = 32'(i + 1);
    total++; if (rx_waitrequest !== 1'b0) begin bad++; $display("FAIL burst_idle_wait got=%b exp=0", rx_waitrequest); end
    rx_start(32'h200, 4);
    for (int s = 0; s < 7; s++) begin
      total++; if (rx_readdatavalid !== (s >= 1 && s <= 4)) begin bad++; $display("FAIL burst_valid s=%0d got=%b exp=%b", s, rx_readdatavalid, (s >= 1 && s <= 4)); end
      total++; if (rx_waitrequest !== (s < 4)) begin bad++; $display("FAIL burst_wait s=%0d got=%b exp=%b", s, rx_waitrequest, (s < 4)); end
      if (s >= 1 && s <= 4) begin
        total++; if (rx_readdata !== 32'(s)) begin bad++; $display("FAIL burst_data s=%0d got=%h exp=%h", s, rx_readdata, 32'(s)); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random_main();
    for (int it = 0; it < 60; it++) begin
      logic [31:0] a, b, d, e;
      logic [3:0]  be;
      int          op;
      a  = alias_addr($urandom_range(0, 15));
      b  = alias_addr($urandom_range(0, 15));
      d  = $urandom;
      e  = $urandom;
      be = 4'($urandom);
      op = $urandom_range(0, 3);
      if (op == 0) main_write(a, d, be);
      else if (op == 1) side_write(a, d);
      else if (op == 2) begin
        address = a; writedata = d; byteenable = be; write = 1;
        wr_port_addr = b; wr_port_data = e; wr_port_valid = 1;
        @(negedge clk);
        write = 0; wr_port_valid = 0;
        ref_mem[widx(a)] = merge(ref_mem[widx(a)], d, be);
        ref_mem[widx(b)] = e;
      end else begin
        main_read(a);
        total++; if (readdata !== ref_mem[widx(a)]) begin bad++; $display("FAIL rand_read it=%0d got=%h exp=%h", it, readdata, ref_mem[widx(a)]); end
      end
    end
  endtask

  task automatic test_random_burst();
    for (int it = 0; it < 10; it++) begin
      int          cnt, eff, start, prev_w, rd_w;
      logic [31:0] d;
      logic        have_prev;
      cnt   = $urandom_range(0, 6);
      eff   = (cnt == 0) ? 1 : cnt;
      start = (it % 2 == 0) ? $urandom_range(DEPTH - 4, DEPTH - 1) : $urandom_range(0, DEPTH - 1);
      for (int b = 0; b < eff; b++) begin
        d = $urandom;
        if (b == 0) tx_beat(alias_addr(start), BURST_W'(cnt), d);
        else tx_beat($urandom, BURST_W'($urandom), d);
        ref_mem[(start + b) % DEPTH] = d;
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      total++; if (rx_waitrequest !== 1'b0) begin bad++; $display("FAIL rand_rx_idle it=%0d got=%b exp=0", it, rx_waitrequest); end
      rx_start(alias_addr(start), BURST_W'(cnt));
      have_prev = 0;
      prev_w    = 0;
      for (int s = 0; s <= eff + 1; s++) begin
        total++; if (rx_readdatavalid !== (s >= 1 && s <= eff)) begin bad++; $display("FAIL rand_rx_valid it=%0d s=%0d got=%b", it, s, rx_readdatavalid); end
        total++; if (rx_waitrequest !== (s < eff)) begin bad++; $display("FAIL rand_rx_wait it=%0d s=%0d got=%b", it, s, rx_waitrequest); end
        if (s >= 1 && s <= eff) begin
          total++; if (rx_readdata !== ref_mem[(start + s - 1) % DEPTH]) begin bad++; $display("FAIL rand_rx_data it=%0d s=%0d got=%h exp=%h", it, s, rx_readdata, ref_mem[(start + s - 1) % DEPTH]); end
        end
        if (have_prev) begin
          total++; if (readdatavalid !== 1'b1 || readdata !== ref_mem[prev_w]) begin bad++; $display("FAIL concurrent_read it=%0d got=%h/%b exp=%h/1", it, readdata, readdatavalid, ref_mem[prev_w]); end
        end
        rd_w    = (start + $urandom_range(0, eff - 1)) % DEPTH;
        address = alias_addr(rd_w);
        read    = 1;
        prev_w  = rd_w;
        have_prev = 1;
        @(negedge clk);
      end
      read = 0;
    end
  endtask

  task automatic test_rx_reset();
    for (int b = 0; b < 8; b++) begin
      logic [31:0] d;
      d = $urandom;
      if (b == 0) tx_beat(32'h1000, 8, d);
      else tx_beat($urandom, BURST_W'($urandom), d);
      ref_mem[widx(32'h1000) + b] = d;
    end
    rx_start(32'h1000, 8);
    repeat (2) @(negedge clk);
    total++; if (rx_readdatavalid !== 1'b1 || rx_readdata !== ref_mem[widx(32'h1000) + 1]) begin bad++; $display("FAIL pre_reset_beat got=%h/%b exp=%h/1", rx_readdata, rx_readdatavalid, ref_mem[widx(32'h1000) + 1]); end
    rst_n = 0;
    #1;
    total++; if (rx_readdatavalid !== 1'b0) begin bad++; $display("FAIL async_drop got=%b exp=0", rx_readdatavalid); end
    total++; if (rx_readdata !== 32'h0) begin bad++; $display("FAIL async_rx_data got=%h exp=%h", rx_readdata, 32'h0); end
    total++; if (tx_waitrequest !== 1'b1) begin bad++; $display("FAIL mid_reset_tx_wait got=%b exp=1", tx_waitrequest); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (rx_readdatavalid !== 1'b0) begin bad++; $display("FAIL no_beats_in_reset i=%0d got=%b exp=0", i, rx_readdatavalid); end
    end
    rst_n = 1;
    #1;
    total++; if (rx_waitrequest !== 1'b0) begin bad++; $display("FAIL release_rx_wait got=%b exp=0", rx_waitrequest); end
    @(negedge clk);
    total++; if (rx_readdatavalid !== 1'b0) begin bad++; $display("FAIL aborted_burst got=%b exp=0", rx_readdatavalid); end
    rx_start(32'h1000, 8);
    for (int s = 0; s <= 9; s++) begin
      total++; if (rx_readdatavalid !== (s >= 1 && s <= 8)) begin bad++; $display("FAIL reread_valid s=%0d got=%b", s, rx_readdatavalid); end
      if (s >= 1 && s <= 8) begin
        total++; if (rx_readdata !== ref_mem[widx(32'h1000) + s - 1]) begin bad++; $display("FAIL reread_data s=%0d got=%h exp=%h", s, rx_readdata, ref_mem[widx(32'h1000) + s - 1]); end
      end
      @(negedge clk);
    end
    main_read(32'h0000_0100);
    total++; if (readdata !== ref_mem[widx(32'h100)]) begin bad++; $display("FAIL data_intact got=%h exp=%h", readdata, ref_mem[widx(32'h100)]); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    idle();
    test_reset();
    test_main_port();
    test_side_alias();
    test_collision();
    test_burst();
    test_random_main();
    test_random_burst();
    test_rx_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
